// File: rtl/mathb_tpram_seq.sv
// Operand/coefficient sequencer: streams a TPRAM run into the math block MAC and captures the dot product.
// Latency: len + RESULT_LAT + 2 cycles from the start edge to the done pulse (len=0 gives done in cycle 1).
// Backpressure: none; start is ignored while a run is in flight, and abort cancels the run on the next cycle.
module mathb_tpram_seq #(
  parameter int ADDR_W     = 9,
  parameter int LEN_W      = 9,
  parameter int RESULT_LAT = 2
) (
  input  logic              EFPGA2MATHB_CLK,
  input  logic              acc_ff_rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] oper_base,
  input  logic [ADDR_W-1:0] coef_base,
  input  logic [LEN_W-1:0]  coef_len,
  input  logic [31:0]       FMATHB_EFPGA_MAC_OUT,
  output logic              TPRAM_OPER_R_EN,
  output logic [ADDR_W-1:0] TPRAM_OPER_R_ADDR,
  output logic              TPRAM_COEF_R_EN,
  output logic [ADDR_W-1:0] TPRAM_COEF_R_ADDR,
  output logic              EFPGA_MATHB_CLK_EN,
  output logic              EFPGA_MATHB_MAC_ACC_CLEAR,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;

  // Run parameters captured on the accepted start cycle.
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  coef_len_q;
  logic [ADDR_W-1:0] oper_base_q;
  logic [ADDR_W-1:0] coef_base_q;

  // idx_q is the beat index i; ring_q is i folded into the coefficient ring.
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  ring_q;
  logic [LEN_W-1:0]  idx_inc;
  logic [LEN_W-1:0]  ring_inc;
  logic [3:0]        drain_q;

  logic              clk_en_q;
  logic              clear_q;
  logic [31:0]       result_q;

  logic              rd_en;
  logic              busy_c;
  logic              done_c;
  logic              last_read;
  logic              drain_last;
  logic              run_start;
  logic              zero_start;

  assign idx_inc    = idx_q + LEN_W'(1);
  assign ring_inc   = ring_q + LEN_W'(1);
  assign last_read  = (idx_inc == len_q);
  assign drain_last = (drain_q == 4'(RESULT_LAT));
  // abort has priority over start in IDLE, so a simultaneous pair starts nothing.
  assign run_start  = start && !abort && (len != '0);
  assign zero_start = start && !abort && (len == '0);

  // State register.
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort pulls FETCH/DRAIN straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run_start) begin
          state_d = S_FETCH;
        end else if (zero_start) begin
          state_d = S_DONE;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_read) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drain_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs: reads in FETCH, busy across FETCH/DRAIN, done in DONE.
  always_comb begin
    rd_en  = 1'b0;
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        rd_en  = 1'b1;
        busy_c = 1'b1;
      end
      S_DRAIN: busy_c = 1'b1;
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  // Capture run parameters on start and step the beat/ring counters during FETCH.
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      len_q       <= '0;
      coef_len_q  <= '0;
      oper_base_q <= '0;
      coef_base_q <= '0;
      idx_q       <= '0;
      ring_q      <= '0;
    end else if (state_q == S_IDLE && run_start) begin
      len_q       <= len;
      coef_len_q  <= coef_len;
      oper_base_q <= oper_base;
      coef_base_q <= coef_base;
      idx_q       <= '0;
      ring_q      <= '0;
    end else if (state_q == S_FETCH && !last_read) begin
      idx_q  <= idx_inc;
      // A zero ring length never matches, so ring_q tracks idx_q (linear addressing).
      ring_q <= (coef_len_q != '0 && ring_inc == coef_len_q) ? '0 : ring_inc;
    end
  end

  // Drain counter: zero on the first DRAIN cycle (the last CLK_EN beat), final at RESULT_LAT.
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      drain_q <= '0;
    end else if (state_q == S_FETCH) begin
      drain_q <= '0;
    end else if (state_q == S_DRAIN && !drain_last) begin
      drain_q <= drain_q + 4'd1;
    end
  end

  // Read data lands one cycle after R_EN, so CLK_EN/CLEAR trail the read; abort kills the in-flight beat.
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      clk_en_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      clk_en_q <= rd_en && !abort;
      clear_q  <= rd_en && !abort && (idx_q == '0);
    end
  end

  // Capture the math-block output once the pipeline has settled; held otherwise.
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      result_q <= '0;
    end else if (state_q == S_DRAIN && drain_last && !abort) begin
      result_q <= FMATHB_EFPGA_MAC_OUT;
    end
  end

  assign TPRAM_OPER_R_EN           = rd_en;
  assign TPRAM_COEF_R_EN           = rd_en;
  assign TPRAM_OPER_R_ADDR         = oper_base_q + ADDR_W'(idx_q);
  assign TPRAM_COEF_R_ADDR         = coef_base_q + ADDR_W'(ring_q);
  assign EFPGA_MATHB_CLK_EN        = clk_en_q;
  assign EFPGA_MATHB_MAC_ACC_CLEAR = clear_q;
  assign busy                      = busy_c;
  assign done                      = done_c;
  assign result                    = result_q;

endmodule

// File: tb/tb_mathb_tpram_seq.sv
// Bench for mathb_tpram_seq: TPRAM + MAC environment, table-driven and random runs, hand-written corner sequences.
// Expected timing comes from the cycle-numbered rules; expected results from a plain dot-product loop.
module tb_mathb_tpram_seq;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 9;
  localparam int RL     = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W-1:0] oper_base = '0;
  logic [ADDR_W-1:0] coef_base = '0;
  logic [LEN_W-1:0]  coef_len = '0;
  logic [31:0]       mac_out;
  logic              oper_ren, coef_ren, clk_en, clr, busy, done;
  logic [ADDR_W-1:0] oper_addr, coef_addr;
  logic [31:0]       result;

  always #5 clk = ~clk;

  mathb_tpram_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RESULT_LAT(RL)) dut (
    .EFPGA2MATHB_CLK          (clk),
    .acc_ff_rstn              (rstn),
    .start                    (start),
    .abort                    (abort),
    .len                      (len),
    .oper_base                (oper_base),
    .coef_base                (coef_base),
    .coef_len                 (coef_len),
    .FMATHB_EFPGA_MAC_OUT     (mac_out),
    .TPRAM_OPER_R_EN          (oper_ren),
    .TPRAM_OPER_R_ADDR        (oper_addr),
    .TPRAM_COEF_R_EN          (coef_ren),
    .TPRAM_COEF_R_ADDR        (coef_addr),
    .EFPGA_MATHB_CLK_EN       (clk_en),
    .EFPGA_MATHB_MAC_ACC_CLEAR(clr),
    .busy                     (busy),
    .done                     (done),
    .result                   (result)
  );

  // Environment: TPRAMs with one-cycle read latency, MAC accumulator plus output register (RL=2).
  logic [31:0] oper_mem [DEPTH];
  logic [31:0] coef_mem [DEPTH];
  logic [31:0] oper_rd, coef_rd, acc;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oper_rd <= '0;
      coef_rd <= '0;
      acc     <= '0;
      mac_out <= '0;
    end else begin
      if (oper_ren) oper_rd <= oper_mem[oper_addr];
      if (coef_ren) coef_rd <= coef_mem[coef_addr];
      if (clk_en) acc <= clr ? oper_rd * coef_rd : acc + oper_rd * coef_rd;
      mac_out <= acc;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = '0;

  logic [5:0]  ctl;
  logic [55:0] all_outs;
  assign ctl      = {oper_ren, coef_ren, clk_en, clr, busy, done};
  assign all_outs = {ctl, oper_addr, coef_addr, result};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference dot product straight from the addressing rules.
  function automatic logic [31:0] ref_dot(input int n, input int ob, input int cb, input int cl);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = s + oper_mem[(ob + i) % DEPTH] * coef_mem[(cb + ((cl == 0) ? i : i % cl)) % DEPTH];
    return s;
  endfunction

  // One run, checked cycle by cycle; returns in the cycle after done.
  task automatic run(input int n, input int ob, input int cb, input int cl,
                     input logic [31:0] exp_res, input int extra_start);
    int last;
    logic [5:0] exp_v;
    len       = LEN_W'(n);
    oper_base = ADDR_W'(ob);
    coef_base = ADDR_W'(cb);
    coef_len  = LEN_W'(cl);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    last  = (n == 0) ? 1 : n + 2 + RL;
    for (int k = 1; k <= last; k++) begin
      exp_v = {k <= n, k <= n, (k >= 2 && k <= n + 1), (k == 2 && n > 0),
               (n > 0 && k <= n + 1 + RL), k == last};
      chk($sformatf("ctl n=%0d cycle=%0d", n, k), 64'(ctl), 64'(exp_v));
      if (k <= n) begin
        chk($sformatf("oper_addr cycle=%0d", k), 64'(oper_addr), 64'((ob + k - 1) % DEPTH));
        chk($sformatf("coef_addr cycle=%0d", k), 64'(coef_addr),
            64'((cb + ((cl == 0) ? k - 1 : (k - 1) % cl)) % DEPTH));
      end
      if (k == last) chk($sformatf("result n=%0d", n), 64'(result), 64'(exp_res));
      if (k == extra_start) begin
        start = 1'b1;
        len = LEN_W'(7); oper_base = '0; coef_base = '0; coef_len = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic idle_check(input string name, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      chk(name, 64'(ctl), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int          n;
    int          ob;
    int          cb;
    int          cl;
    logic [31:0] exp_res;
    int          mode;  // 0: constant exp_res, 1: reference model, 2: previous result
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [31:0] e;
    int n, ob, cb, cl;

    tbl[0] = '{4, 'h010, 'h100, 0, 32'd70, 0};
    tbl[1] = '{5, 'h020, 'h1FE, 3, 32'd0, 1};
    tbl[2] = '{3, 'h1FF, 'h040, 0, 32'd0, 1};
    tbl[3] = '{0, 'h033, 'h044, 0, 32'd0, 2};

    for (int i = 0; i < DEPTH; i++) begin
      oper_mem[i] = $urandom;
      coef_mem[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      oper_mem['h010 + i] = 32'(i + 1);
      coef_mem['h100 + i] = 32'(i + 5);
    end

    #2;
    chk("reset outputs", 64'(all_outs), 64'(0));
    #20;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      case (tbl[t].mode)
        0:       e = tbl[t].exp_res;
        1:       e = ref_dot(tbl[t].n, tbl[t].ob, tbl[t].cb, tbl[t].cl);
        default: e = last_res;
      endcase
      run(tbl[t].n, tbl[t].ob, tbl[t].cb, tbl[t].cl, e, 0);
      last_res = e;
    end

    for (int r = 0; r < 25; r++) begin
      n  = int'($urandom_range(1, 20));
      ob = int'($urandom_range(0, DEPTH - 1));
      cb = int'($urandom_range(0, DEPTH - 1));
      cl = int'($urandom_range(0, 5));
      e  = ref_dot(n, ob, cb, cl);
      run(n, ob, cb, cl, e, 0);
      last_res = e;
    end

    // start pulsed mid-run and in the done cycle is ignored.
    e = ref_dot(6, 'h080, 'h090, 4);
    run(6, 'h080, 'h090, 4, e, 3);
    last_res = e;
    idle_check("busy start ignored", 3);
    e = ref_dot(5, 'h0A0, 'h0B0, 0);
    run(5, 'h0A0, 'h0B0, 0, e, 5 + 2 + RL);
    last_res = e;
    idle_check("done start ignored", 3);

    // Abort in cycle 3 of a len=8 run.
    len = LEN_W'(8); oper_base = ADDR_W'('h005); coef_base = ADDR_W'('h009); coef_len = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort pre ctl cycle 3", 64'(ctl), 64'(6'b111010));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort cycle 4 ctl", 64'(ctl), 64'(0));
    idle_check("abort no done", 14);
    chk("abort result held", 64'(result), 64'(last_res));

    // start with abort in IDLE.
    len = LEN_W'(4); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    idle_check("start+abort", 8);
    chk("start+abort result", 64'(result), 64'(last_res));

    // Asynchronous reset in the middle of DRAIN.
    len = LEN_W'(4); oper_base = ADDR_W'('h150); coef_base = ADDR_W'('h160); coef_len = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
    end
    chk("drain busy before reset", 64'(busy), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("async reset outputs", 64'(all_outs), 64'(0));
    #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    e = ref_dot(7, 'h1F0, 'h0C0, 2);
    run(7, 'h1F0, 'h0C0, 2, e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mathb_tpram_seq.md
# mathb_tpram_seq

Operand/coefficient sequencer sitting directly upstream of the math block. On a start pulse it reads a run of operand and coefficient words from the two TPRAMs and drives the math block clock-enable and accumulator-clear strobes so that one dot product accumulates over the run. It then waits out the math-block pipeline, captures the registered MAC output and reports completion with a one-cycle done pulse. The host puts the math block in TPRAM mode (OPER/COEF defPin = 2'b10) while this block is running.

## Interface

- ADDR_W, 9: TPRAM read address width.
- LEN_W, 9: run-length width.
- RESULT_LAT, 2: cycles from the last CLK_EN beat until the math block's registered output holds the final value (accumulator plus output FF). Legal range is 1..15.

- EFPGA2MATHB_CLK  in  1  clock, rising edge.
- acc_ff_rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; honoured only in IDLE.
- abort  in  1  cancels the current run.
- len  in  LEN_W  number of MAC beats; sampled on the start cycle.
- oper_base  in  ADDR_W  first operand address; sampled on the start cycle.
- coef_base  in  ADDR_W  first coefficient address; sampled on the start cycle.
- coef_len  in  LEN_W  coefficient ring length; 0 means linear addressing. Sampled on the start cycle.
- FMATHB_EFPGA_MAC_OUT  in  32  registered math-block result.
- TPRAM_OPER_R_EN  out  1  operand read enable.
- TPRAM_OPER_R_ADDR  out  ADDR_W  operand read address.
- TPRAM_COEF_R_EN  out  1  coefficient read enable.
- TPRAM_COEF_R_ADDR  out  ADDR_W  coefficient read address.
- EFPGA_MATHB_CLK_EN  out  1  accumulate enable to the math block.
- EFPGA_MATHB_MAC_ACC_CLEAR  out  1  accumulator clear, asserted with the first beat.
- busy  out  1  high from the cycle after start until done, or until abort takes effect.
- done  out  1  one-cycle completion pulse.
- result  out  32  captured result; held between runs.

## Operation

- Reset: every output is 0. The FSM is in IDLE and all internal counters are 0.
- States:
  - IDLE:
    - start with len≠0 and no abort → FETCH.
    - start with len=0 → DONE. No reads are issued and result is unchanged.
  - FETCH: issue read i = 0..len-1, one per cycle.
    - TPRAM_OPER_R_ADDR = oper_base+i, modulo 2^ADDR_W.
    - TPRAM_COEF_R_ADDR = coef_base + (coef_len==0 ? i : i mod coef_len), modulo 2^ADDR_W.
    - After the last read → DRAIN.
  - DRAIN: count RESULT_LAT cycles after the last CLK_EN beat. On the final count, load result from FMATHB_EFPGA_MAC_OUT → DONE.
  - DONE: done=1 for one cycle → IDLE.
- TPRAM read data is valid the cycle after R_EN. EFPGA_MATHB_CLK_EN is therefore R_EN delayed by one cycle. ACC_CLEAR is high only on the first CLK_EN cycle; clear-with-enable loads the first product and does not add it.
- start while busy is ignored.
- abort in FETCH or DRAIN:
  - Next cycle the FSM is in IDLE with R_EN, CLK_EN and busy at 0.
  - There is no done pulse and result is unchanged.
  - An in-flight delayed CLK_EN is suppressed.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- start in the DONE cycle is ignored.
- Asynchronous reset mid-run forces the reset values immediately.

## Timing

- start is sampled at edge E0; cycle k is the cycle after edge Ek.
- Reads are issued in cycles 1..len; busy=1 from cycle 1.
- CLK_EN is high in cycles 2..len+1. ACC_CLEAR is high in cycle 2 only.
- result loads at the end of cycle len+1+RESULT_LAT.
- done=1 in cycle len+2+RESULT_LAT. busy=0 in that same cycle, and result is already valid.
- Back-to-back runs: the earliest next start is sampled in the cycle after done.
- len=0: busy=0 throughout, and done=1 in cycle 1.
- Total cycles for one run: len+RESULT_LAT+2.

## Test plan

- Linear run:
  - Stimulus: len=4, oper_base=0x010, coef_base=0x100, coef_len=0, RESULT_LAT=2; operands 1,2,3,4; coefs 5,6,7,8.
  - Response: OPER addresses 0x010..0x013 in cycles 1..4; CLK_EN in cycles 2..5; CLEAR only in cycle 2; done in cycle 8 with result=70 (0x46).
- Coefficient ring:
  - Stimulus: len=5, coef_base=0x1FE, coef_len=3, ADDR_W=9.
  - Response: COEF addresses 0x1FE, 0x1FF, 0x000, 0x1FE, 0x1FF.
- Operand address wrap:
  - Stimulus: oper_base=0x1FF, len=3.
  - Response: OPER addresses 0x1FF, 0x000, 0x001.
- Abort:
  - Stimulus: abort in cycle 3 of a len=8 run.
  - Response: R_EN and CLK_EN are 0 from cycle 4; busy falls in cycle 4; no done pulse; result keeps its previous value.
- Edge requests:
  - len=0 → done in cycle 1 with result unchanged.
  - start pulsed while busy → ignored.
  - start and abort together in IDLE → no run.
- Reset mid-DRAIN:
  - Stimulus: drive acc_ff_rstn low asynchronously.
  - Response: all outputs 0 immediately.
  - Follow-up: a fresh start after release completes normally with the correct result.
